data_sampling: RTL
==================

DATA_SAMPLING -- requirements
Module: data_sampling

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 6, width of the prescale input and edge counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port rx_in  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
REQ-006 SHALL have port data_samp_en  input  1  enables edge counting and sampling.
REQ-007 SHALL have port sampled_bit  output  1  registered majority-voted bit value.
REQ-008 SHALL have port finish  output  1  one-cycle pulse marking sampled_bit as newly valid.
REQ-009 SHALL have port bit_done  output  1  one-cycle pulse at the last edge of each bit period.
REQ-010 SHALL have port edge_cnt  output  PRESCALE_W  current oversampling edge index.

Function
REQ-011 SHALL pass rx_in through a 2-flop synchronizer, with both flops reset to 1; rx_s denotes the second flop output.
REQ-012 SHALL use P = prescale when prescale is 8, 16 or 32, and P = 16 for any other value.
REQ-013 SHALL increment edge_cnt by 1 per clk while data_samp_en=1, wrapping from P-1 to 0.
REQ-014 SHALL load edge_cnt with 0 on the next edge whenever data_samp_en=0.
REQ-015 SHALL wrap edge_cnt to 0 when it is at or above P-1 at a clock edge, covering a prescale decrease during operation.
REQ-016 SHALL capture rx_s into sample s0 at the edge where edge_cnt == P/2-1 with data_samp_en=1.
REQ-017 SHALL capture rx_s into sample s1 at the edge where edge_cnt == P/2 with data_samp_en=1.
REQ-018 SHALL, at the edge where edge_cnt == P/2+1 with data_samp_en=1, load sampled_bit with majority(s0, s1, rx_s) and set finish=1.
REQ-019 SHALL hold finish high for exactly one cycle, i.e. while edge_cnt == P/2+2.
REQ-020 SHALL set bit_done=1 for one cycle following the edge where edge_cnt == P-1 with data_samp_en=1.
REQ-021 SHALL hold sampled_bit between updates, including while data_samp_en=0.
REQ-022 SHALL, when data_samp_en falls mid-bit, clear edge_cnt, s0 and s1 (to 1) and suppress any pending finish or bit_done.
REQ-023 SHALL make the latency from an rx_in change to its effect on rx_s exactly 2 cycles.
REQ-024 SHALL produce exactly one finish pulse and one bit_done pulse per P enabled cycles.
REQ-025 SHALL be glitch-tolerant: a single rx_s sample disagreeing with the other two does not change the majority result.
REQ-026 SHALL treat the prescale value as live; changes are permitted only while data_samp_en=0, and behaviour otherwise is bounded only by REQ-015.

Reset
REQ-027 SHALL, with rst=0 at a clock edge, set edge_cnt=0, sampled_bit=1, finish=0, bit_done=0, s0=s1=1 and both synchronizer flops to 1.
REQ-028 SHALL give reset priority over data_samp_en, including reset asserted mid-bit.
REQ-029 SHALL, after rst deasserts, start the first bit period at edge_cnt=0 on the first enabled edge.

Verification
REQ-030 SHALL verify: prescale=8, en=1, rx_in held 0 -> finish high at edge_cnt=6, sampled_bit=0, bit_done after edge_cnt=7, period 8 cycles.
REQ-031 SHALL verify: prescale=16, rx_s=1 at edge 7 only, 0 at edges 8 and 9 -> sampled_bit=0 (glitch rejected).
REQ-032 SHALL verify: prescale=32, 10 consecutive bits of alternating data -> 10 finish pulses, 32 cycles apart, with matching sampled_bit values.
REQ-033 SHALL verify: en dropped at edge_cnt=8 with prescale=16 -> no finish, edge_cnt=0 next cycle, sampled_bit unchanged.
REQ-034 SHALL verify: prescale=20 -> behaves exactly as 16 (finish at edge_cnt=10).
REQ-035 SHALL verify: rst=0 mid-bit at edge_cnt=5 -> all outputs at reset values next cycle; counting restarts from 0 after release.

Source files
------------

// File: rtl/data_sampling.sv
// ---------------------------------------------------------------------------
// data_sampling
// Oversampling bit sampler for a UART-style receiver. The serial line is
// synchronized, an edge counter runs across each bit period of P clocks, and
// three consecutive samples around the bit centre are majority-voted into
// sampled_bit.
//
// Ports
//   clk          : system clock, all state on rising edge
//   rst          : synchronous reset, active low
//   rx_in        : asynchronous serial line, idle high
//   prescale     : oversampling ratio (8, 16, 32; anything else runs as 16)
//   data_samp_en : enables edge counting and sampling
//   sampled_bit  : registered majority-voted bit value
//   finish       : one-cycle pulse, sampled_bit newly valid
//   bit_done     : one-cycle pulse after the last edge of a bit period
//   edge_cnt     : current oversampling edge index
// ---------------------------------------------------------------------------
module data_sampling #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  data_samp_en,
  output logic                  sampled_bit,
  output logic                  finish,
  output logic                  bit_done,
  output logic [PRESCALE_W-1:0] edge_cnt
);

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic                  s0_q, s0_d;
  logic                  s1_q, s1_d;
  logic                  sampled_q, sampled_d;
  logic                  finish_q, finish_d;
  logic                  bit_done_q, bit_done_d;

  logic [PRESCALE_W-1:0] p_val;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last;
  logic                  majority;

  // Unsupported ratios fall back to 16 so the counter always has a sane period.
  always_comb begin
    if (prescale == PRESCALE_W'(8) || prescale == PRESCALE_W'(16) ||
        prescale == PRESCALE_W'(32))
      p_val = prescale;
    else
      p_val = PRESCALE_W'(16);
  end

  assign half     = p_val >> 1;
  assign last     = p_val - PRESCALE_W'(1);
  assign majority = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);

  always_comb begin
    sync1_d    = rx_in;
    sync2_d    = sync1_q;
    edge_cnt_d = edge_cnt_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    sampled_d  = sampled_q;
    finish_d   = 1'b0;
    bit_done_d = 1'b0;

    if (!data_samp_en) begin
      // Abandoning a bit discards partial samples and any pending pulses.
      edge_cnt_d = '0;
      s0_d       = 1'b1;
      s1_d       = 1'b1;
    end else begin
      // ">=" rather than "==" recovers if prescale shrank under a running count.
      if (edge_cnt_q >= last)
        edge_cnt_d = '0;
      else
        edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);

      if (edge_cnt_q == half - PRESCALE_W'(1))
        s0_d = sync2_q;
      if (edge_cnt_q == half)
        s1_d = sync2_q;
      // Third sample is the live synchronizer output, voted in the same edge.
      if (edge_cnt_q == half + PRESCALE_W'(1)) begin
        sampled_d = majority;
        finish_d  = 1'b1;
      end
      if (edge_cnt_q == last)
        bit_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      edge_cnt_q <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      sampled_q  <= 1'b1;
      finish_q   <= 1'b0;
      bit_done_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      edge_cnt_q <= edge_cnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      sampled_q  <= sampled_d;
      finish_q   <= finish_d;
      bit_done_q <= bit_done_d;
    end
  end

  assign sampled_bit = sampled_q;
  assign finish      = finish_q;
  assign bit_done    = bit_done_q;
  assign edge_cnt    = edge_cnt_q;

endmodule
